aes_output_serializer: RTL and testbench
========================================

# aes_output_serializer

Downstream stage of the AES-128 core. Captures each 128-bit ciphertext block on the core's single-cycle `output_valid` pulse into a small block FIFO, then streams it out as 32-bit words over a valid/ready interface, most-significant word first. It decouples the core, which has no backpressure, from a slower or stalling consumer, and flags any block lost to overflow.

## Interface
Parameters:
- `WORD_WIDTH`, 32: output word width; must divide 128 evenly.
- `DEPTH`, 2: block FIFO entries; power of two, ≥ 2.

Ports:
- `clk` input 1: single clock; all logic on rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `output_valid` input 1: AES core result strobe; each cycle high is one block.
- `cipher_text` input 128: AES core result, valid when `output_valid`=1.
- `word_out` output WORD_WIDTH: current output word.
- `word_valid` output 1: `word_out` is valid.
- `word_ready` input 1: consumer accepts the word this cycle.
- `word_last` output 1: current word is the final word of its block.
- `blocks_pending` output $clog2(DEPTH)+1: number of stored blocks, including any block that is partly sent.
- `overflow` output 1: sticky; set when a block is dropped.

## Operation
- Write: on `output_valid`=1, write `cipher_text` to the FIFO tail if it is not full. If the FIFO is full and no block frees this cycle, drop the block and set `overflow`. `overflow` clears only on reset.
- Read FSM with two states:
  - IDLE: `word_valid`=0. Go to STREAM when `blocks_pending`>0.
  - STREAM: `word_valid`=1.
- Word index `idx` runs 0..N-1, where N=128/WORD_WIDTH.
- `word_out` = head[127-idx·WORD_WIDTH -: WORD_WIDTH].
- `word_last` = (idx==N-1) & `word_valid`.
- Handshake: a word transfers when `word_valid` & `word_ready`.
  - On a transfer with idx<N-1: idx increments.
  - On a transfer with idx==N-1: idx goes to 0 and the head is popped.
  - After the pop, stay in STREAM if another block is pending; otherwise go to IDLE.
- Stall: while `word_valid`=1 and `word_ready`=0, `word_out`, `word_last` and idx hold.
- Simultaneous write and final-word pop while full: the write is accepted, no overflow, `blocks_pending` stays DEPTH.
- Simultaneous write and pop when not full: `blocks_pending` is unchanged.
- `blocks_pending` = count of entries. It increments on an accepted write, decrements on a pop, and saturates at DEPTH.
- FIFO pointers wrap modulo DEPTH.

## Timing
- Reset values: `word_valid`=0, `word_last`=0, `word_out`=0, `blocks_pending`=0, `overflow`=0, FSM=IDLE, idx=0, pointers=0.
- Reset asserted mid-stream: all outputs go to reset values immediately (asynchronous) and buffered blocks are discarded.
- Latency: `output_valid` sampled at edge E with FIFO empty → `word_valid`=1 and word 0 on `word_out` after edge E+1 (one registered cycle).
- Throughput: one word per cycle with `word_ready` held high. With `word_ready` high, back-to-back blocks stream with no bubble between the last word of one block and word 0 of the next.
- Minimum time per block: N cycles. The core produces at most one block per 10+ cycles, so with DEPTH=2 overflow only occurs under consumer stall.
- `overflow` rises in the cycle after the dropped strobe is sampled.

## Test plan
- Single block: `cipher_text`=128'h3925841D_02DC09FB_DC118597_196A0B32, `word_ready`=1 → words 3925841D, 02DC09FB, DC118597, 196A0B32 on 4 consecutive cycles, starting one cycle after the strobe; `word_last` high only on 196A0B32; `blocks_pending` 1→0.
- Stall: drop `word_ready` during word 1 for 5 cycles → `word_out`=02DC09FB held stable, idx unchanged, then the stream resumes with DC118597.
- Overflow: `word_ready`=0, strobe 3 distinct blocks → `blocks_pending`=2, `overflow`=1. Then release `word_ready` → only the first two blocks appear, in order (8 words).
- Full with simultaneous write and final-word pop → block accepted, `overflow` stays 0, `blocks_pending` stays 2, and all 3 blocks stream out in order.
- Reset mid-stream: assert `rst`=0 after word 1 of a block with another block pending → all outputs go to 0 immediately. After release, nothing streams until a new strobe arrives.
- Back-to-back: two blocks buffered, `word_ready`=1 → 8 consecutive valid words, `word_last` on words 3 and 7.

Source files
------------

// File: rtl/aes_output_serializer.sv
// Buffers 128-bit AES results in a small block FIFO and streams each block
// out as WORD_WIDTH-bit words, most-significant word first, over valid/ready.
module aes_output_serializer #(
  parameter int WORD_WIDTH = 32,
  parameter int DEPTH      = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    output_valid,
  input  logic [127:0]            cipher_text,
  output logic [WORD_WIDTH-1:0]   word_out,
  output logic                    word_valid,
  input  logic                    word_ready,
  output logic                    word_last,
  output logic [$clog2(DEPTH):0]  blocks_pending,
  output logic                    overflow
);

  localparam int N     = 128 / WORD_WIDTH;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  typedef enum logic {S_IDLE, S_STREAM} state_e;

  state_e             state_q, state_d;
  logic [127:0]       mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               overflow_q, overflow_d;

  logic               streaming;
  logic               full;
  logic               xfer;
  logic               pop;
  logic               wr_accept;
  logic [127:0]       head;
  logic [WORD_WIDTH-1:0] head_words [N];

  assign streaming = (state_q == S_STREAM);
  assign full      = (count_q == CNT_FULL);
  assign xfer      = streaming & word_ready;
  assign pop       = xfer & (idx_q == IDX_LAST);
  // A final-word pop frees the head slot in the same edge, so a full FIFO
  // can still take a new block without dropping it.
  assign wr_accept = output_valid & (~full | pop);
  assign head      = mem_q[rd_ptr_q];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_slice
      localparam int HI = 127 - gi * WORD_WIDTH;
      assign head_words[gi] = head[HI -: WORD_WIDTH];
    end
  endgenerate

  // Block storage carries no reset; clearing the pointers discards contents.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem_q[wr_ptr_q] <= cipher_text;
    end
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    idx_d      = idx_q;
    overflow_d = overflow_q | (output_valid & ~wr_accept);
    if (wr_accept) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({wr_accept, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (xfer) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      idx_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      idx_q      <= idx_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Leaving STREAM looks at the post-pop count so a queued block follows
  // its predecessor with no idle cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        if (pop && (count_d == '0)) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    word_valid = 1'b0;
    word_last  = 1'b0;
    word_out   = '0;
    if (streaming) begin
      word_valid = 1'b1;
      word_last  = (idx_q == IDX_LAST);
      word_out   = head_words[idx_q];
    end
  end

  assign blocks_pending = count_q;
  assign overflow       = overflow_q;

endmodule

// File: tb/tb_aes_output_serializer.sv
// Self-checking bench for aes_output_serializer: vector table plus a word
// scoreboard fed at strobe time and drained by a negedge monitor.
module tb_aes_output_serializer;

  logic         clk = 1'b0;
  logic         rst;
  logic         output_valid;
  logic [127:0] cipher_text;
  logic [31:0]  word_out;
  logic         word_valid;
  logic         word_ready;
  logic         word_last;
  logic [1:0]   blocks_pending;
  logic         overflow;

  always #5 clk = ~clk;

  aes_output_serializer #(.WORD_WIDTH(32), .DEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .output_valid   (output_valid),
    .cipher_text    (cipher_text),
    .word_out       (word_out),
    .word_valid     (word_valid),
    .word_ready     (word_ready),
    .word_last      (word_last),
    .blocks_pending (blocks_pending),
    .overflow       (overflow)
  );

  typedef struct {
    logic [127:0] ct;
    logic [31:0]  w0;
    logic [31:0]  w1;
    logic [31:0]  w2;
    logic [31:0]  w3;
  } vec_t;

  typedef struct {
    logic [31:0] w;
    logic        l;
  } exp_t;

  vec_t vecs [5];
  exp_t sb_q [$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic push_block(input int v);
    sb_q.push_back('{vecs[v].w0, 1'b0});
    sb_q.push_back('{vecs[v].w1, 1'b0});
    sb_q.push_back('{vecs[v].w2, 1'b0});
    sb_q.push_back('{vecs[v].w3, 1'b1});
  endtask

  task automatic strobe(input logic [127:0] ct);
    @(posedge clk); #1;
    output_valid = 1'b1;
    cipher_text  = ct;
    @(posedge clk); #1;
    output_valid = 1'b0;
    cipher_text  = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && sb_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    check("drain_empty", 128'(sb_q.size()), 128'(0));
    check("idle_after_drain", 128'(word_valid), 128'(0));
  endtask

  // Scoreboard monitor: a word transfers on the edge after valid&ready is seen.
  always @(negedge clk) begin
    if (rst && word_valid && word_ready) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_word: got %h expected none", word_out);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        $display("xfer word=%h last=%b pending=%0d", word_out, word_last, blocks_pending);
        check("word", 128'(word_out), 128'(e.w));
        check("last", 128'(word_last), 128'(e.l));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [6:0] vh7;
    logic [9:0] vh10;
    logic [9:0] lh10;
    logic [1:0] pend1;
    logic [1:0] pend6;
    logic       any_valid;

    vecs[0] = '{128'h3925841D_02DC09FB_DC118597_196A0B32, 32'h3925841D, 32'h02DC09FB, 32'hDC118597, 32'h196A0B32};
    vecs[1] = '{128'h00112233_44556677_8899AABB_CCDDEEFF, 32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};
    vecs[2] = '{128'hDEADBEEF_01234567_89ABCDEF_FEDCBA98, 32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98};
    vecs[3] = '{128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'h0F0F0F0F, 32'hF0F0F0F0};
    vecs[4] = '{128'h69C4E0D8_6A7B0430_D8CDB780_70B4C55A, 32'h69C4E0D8, 32'h6A7B0430, 32'hD8CDB780, 32'h70B4C55A};

    rst = 1'b0; output_valid = 1'b0; cipher_text = '0; word_ready = 1'b0;
    #1;
    check("rst_word_valid", 128'(word_valid), 128'(0));
    check("rst_word_last", 128'(word_last), 128'(0));
    check("rst_word_out", 128'(word_out), 128'(0));
    check("rst_pending", 128'(blocks_pending), 128'(0));
    check("rst_overflow", 128'(overflow), 128'(0));
    do_reset();

    // Table: single blocks, ready held high; latency and pending profile.
    word_ready = 1'b1;
    for (int v = 0; v < 3; v++) begin
      push_block(v);
      strobe(vecs[v].ct);
      vh7 = '0; pend1 = '0; pend6 = '0;
      for (int k = 1; k <= 7; k++) begin
        @(negedge clk);
        vh7 = {vh7[5:0], word_valid};
        if (k == 1) pend1 = blocks_pending;
        if (k == 6) pend6 = blocks_pending;
      end
      check("single_valid_profile", 128'(vh7), 128'(7'b0111100));
      check("single_pending_start", 128'(pend1), 128'(1));
      check("single_pending_end", 128'(pend6), 128'(0));
      wait_drain(20);
    end

    // Stall on word 1 for five cycles.
    push_block(0);
    strobe(vecs[0].ct);
    @(posedge clk); #1;
    @(posedge clk); #1;
    word_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_word", 128'(word_out), 128'(32'h02DC09FB));
      check("stall_valid", 128'(word_valid), 128'(1));
      check("stall_last", 128'(word_last), 128'(0));
    end
    @(posedge clk); #1;
    word_ready = 1'b1;
    wait_drain(20);

    // Overflow: three strobes under stall, only the first two survive.
    word_ready = 1'b0;
    push_block(1); push_block(2);
    strobe(vecs[1].ct);
    strobe(vecs[2].ct);
    check("ovf_before", 128'(overflow), 128'(0));
    strobe(vecs[3].ct);
    check("ovf_set", 128'(overflow), 128'(1));
    check("ovf_pending", 128'(blocks_pending), 128'(2));
    @(posedge clk); #1;
    word_ready = 1'b1;
    wait_drain(40);
    check("ovf_sticky", 128'(overflow), 128'(1));
    check("ovf_pending_end", 128'(blocks_pending), 128'(0));
    do_reset();
    check("ovf_cleared", 128'(overflow), 128'(0));

    // Full FIFO with a write landing on the final-word pop edge.
    word_ready = 1'b0;
    push_block(4); push_block(0); push_block(1);
    strobe(vecs[4].ct);
    strobe(vecs[0].ct);
    check("full_pending", 128'(blocks_pending), 128'(2));
    @(posedge clk); #1;
    word_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    output_valid = 1'b1;
    cipher_text  = vecs[1].ct;
    @(posedge clk); #1;
    output_valid = 1'b0;
    cipher_text  = '0;
    check("fullpop_overflow", 128'(overflow), 128'(0));
    check("fullpop_pending", 128'(blocks_pending), 128'(2));
    wait_drain(40);

    // Reset mid-stream after word 1 with a second block queued.
    word_ready = 1'b1;
    sb_q.push_back('{vecs[0].w0, 1'b0});
    sb_q.push_back('{vecs[0].w1, 1'b0});
    strobe(vecs[0].ct);
    strobe(vecs[1].ct);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("midrst_valid", 128'(word_valid), 128'(0));
    check("midrst_word", 128'(word_out), 128'(0));
    check("midrst_last", 128'(word_last), 128'(0));
    check("midrst_pending", 128'(blocks_pending), 128'(0));
    check("midrst_queue", 128'(sb_q.size()), 128'(0));
    @(posedge clk); #1;
    rst = 1'b1;
    any_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      any_valid = any_valid | word_valid;
    end
    check("postrst_quiet", 128'(any_valid), 128'(0));
    push_block(4);
    strobe(vecs[4].ct);
    wait_drain(20);

    // Back-to-back: two buffered blocks, eight words with no bubble.
    word_ready = 1'b0;
    push_block(2); push_block(3);
    strobe(vecs[2].ct);
    strobe(vecs[3].ct);
    @(posedge clk); #1;
    word_ready = 1'b1;
    vh10 = '0; lh10 = '0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      vh10 = {vh10[8:0], word_valid};
      lh10 = {lh10[8:0], word_last};
    end
    check("b2b_valid_profile", 128'(vh10), 128'(10'b1111111100));
    check("b2b_last_profile", 128'(lh10), 128'(10'b0001000100));
    wait_drain(20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
